// File: rtl/vga_ctrl_pkg.sv
// Shared constants for the VGA control front end: button FSM state encoding,
// repeat-counter width and default timing, plus a saturating increment helper.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int RPT_CNT_W        = 8;
  localparam int DEFAULT_DELAY_MS = 500;
  localparam int DEFAULT_RATE_MS  = 100;

  function automatic logic [RPT_CNT_W-1:0] sat_inc(input logic [RPT_CNT_W-1:0] v);
    return (v == {RPT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/button_repeat_edge_detect.sv
// Registers a button level and reports its rising and falling edges.
// Shared by every pushbutton on the board.
module edge_detect (
  input  logic clk_1KHz,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic btn_q;

  always_ff @(posedge clk_1KHz) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= level;
  end

  assign rise = level & ~btn_q;
  assign fall = ~level & btn_q;

endmodule

// File: rtl/button_repeat.sv
// Turns a debounced button level into press/release strobes, a hold-to-repeat
// step train, a long-press flag and a saturating repeat count.
module button_repeat
  import vga_ctrl_pkg::*;
#(
  parameter int DELAY_MS = DEFAULT_DELAY_MS,
  parameter int RATE_MS  = DEFAULT_RATE_MS,
  parameter int CNT_W    = 10
) (
  input  logic                 clk_1KHz,
  input  logic                 rst,
  input  logic                 debounced,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic                 rpt_pulse,
  output logic                 step,
  output logic                 long_press,
  output logic [RPT_CNT_W-1:0] rpt_count
);

  generate
    if (DELAY_MS < 2 || DELAY_MS > 1023 || RATE_MS < 2 || RATE_MS > 1023)
      begin : g_bad_timing
        $error("button_repeat: DELAY_MS and RATE_MS must lie in 2..1023");
      end
    if ((2 ** CNT_W) <= DELAY_MS || (2 ** CNT_W) <= RATE_MS)
      begin : g_bad_width
        $error("button_repeat: CNT_W too narrow for DELAY_MS/RATE_MS");
      end
  endgenerate

  logic rise, fall;

  edge_detect u_edge (
    .clk_1KHz (clk_1KHz),
    .rst      (rst),
    .level    (debounced),
    .rise     (rise),
    .fall     (fall)
  );

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     counter_reg, counter_next;
  logic                 press_reg, press_next;
  logic                 release_reg, release_next;
  logic                 rpt_reg, rpt_next;
  logic                 step_reg, step_next;
  logic                 long_reg, long_next;
  logic [RPT_CNT_W-1:0] rpt_count_reg, rpt_count_next;

  logic delay_done, rate_done;
  assign delay_done = (counter_reg == CNT_W'(DELAY_MS - 1));
  assign rate_done  = (counter_reg == CNT_W'(RATE_MS - 1));

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      state_reg     <= IDLE;
      counter_reg   <= '0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      rpt_reg       <= 1'b0;
      step_reg      <= 1'b0;
      long_reg      <= 1'b0;
      rpt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      rpt_reg       <= rpt_next;
      step_reg      <= step_next;
      long_reg      <= long_next;
      rpt_count_reg <= rpt_count_next;
    end
  end

  // A release always beats a terminal count arriving on the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = WAIT;
      WAIT:    if (fall) state_next = IDLE;
               else if (delay_done) state_next = REPEAT;
      REPEAT:  if (fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    counter_next   = counter_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    rpt_next       = 1'b0;
    long_next      = long_reg;
    rpt_count_next = rpt_count_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          press_next     = 1'b1;
          counter_next   = '0;
          rpt_count_next = '0;
        end
      end
      WAIT: begin
        if (fall) begin
          release_next = 1'b1;
        end else if (delay_done) begin
          rpt_next       = 1'b1;
          long_next      = 1'b1;
          counter_next   = '0;
          rpt_count_next = RPT_CNT_W'(1);
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          release_next = 1'b1;
          long_next    = 1'b0;
        end else if (rate_done) begin
          rpt_next       = 1'b1;
          counter_next   = '0;
          rpt_count_next = sat_inc(rpt_count_reg);
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      default: begin
        counter_next = '0;
        long_next    = 1'b0;
      end
    endcase
    step_next = press_next | rpt_next;
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign rpt_pulse     = rpt_reg;
  assign step          = step_reg;
  assign long_press    = long_reg;
  assign rpt_count     = rpt_count_reg;

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat with DELAY_MS=5, RATE_MS=3.
// Flag vectors are {press_pulse, release_pulse, rpt_pulse, step, long_press}.
module tb_button_repeat;

  logic       clk_1KHz = 1'b0;
  logic       rst;
  logic       debounced;
  logic       press_pulse, release_pulse, rpt_pulse, step, long_press;
  logic [7:0] rpt_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  button_repeat #(.DELAY_MS(5), .RATE_MS(3), .CNT_W(10)) dut (
    .clk_1KHz      (clk_1KHz),
    .rst           (rst),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .rpt_pulse     (rpt_pulse),
    .step          (step),
    .long_press    (long_press),
    .rpt_count     (rpt_count)
  );

  always #5 clk_1KHz = ~clk_1KHz;

  logic [4:0] flags;
  assign flags = {press_pulse, release_pulse, rpt_pulse, step, long_press};

  task automatic tick;
    @(posedge clk_1KHz);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    debounced = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({flags, rpt_count} !== 13'd0)
      $display("FAIL reset_outputs: got %b, want 0", {flags, rpt_count});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (flags !== 5'b10010) $display("FAIL reset_held_press: got %b, want 10010", flags);
    else pass_cnt++;
    debounced = 1'b0;
    tick();
    total_cnt++;
    if (flags !== 5'b01000) $display("FAIL reset_held_release: got %b, want 01000", flags);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags !== 5'b00000) $display("FAIL reset_idle: got %b, want 00000", flags);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_hold20;
    logic       exp_rpt;
    logic [7:0] exp_cnt;
    exp_cnt = 8'd0;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b10010, 8'd0})
      $display("FAIL hold20_press: got %b/%0d, want 10010/0", flags, rpt_count);
    else pass_cnt++;
    for (int i = 1; i < 20; i++) begin
      tick();
      exp_rpt = (i >= 5) && ((i - 5) % 3 == 0);
      if (exp_rpt) exp_cnt++;
      total_cnt++;
      if ({flags, rpt_count} !== {2'b00, exp_rpt, exp_rpt, (i >= 5), exp_cnt})
        $display("FAIL hold20_k+%0d: got %b/%0d, want %b/%0d", i, flags, rpt_count,
                 {2'b00, exp_rpt, exp_rpt, (i >= 5)}, exp_cnt);
      else pass_cnt++;
    end
    debounced = 1'b0;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b01000, 8'd5})
      $display("FAIL hold20_release: got %b/%0d, want 01000/5", flags, rpt_count);
    else pass_cnt++;
    $display("test_hold20 done");
  endtask

  task automatic test_short_press;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if (flags !== 5'b10010) $display("FAIL short_press: got %b, want 10010", flags);
    else pass_cnt++;
    repeat (2) begin
      tick();
      total_cnt++;
      if (flags !== 5'b00000) $display("FAIL short_hold: got %b, want 00000", flags);
      else pass_cnt++;
    end
    debounced = 1'b0;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b01000, 8'd0})
      $display("FAIL short_release: got %b/%0d, want 01000/0", flags, rpt_count);
    else pass_cnt++;
    $display("test_short_press done");
  endtask

  task automatic test_fall_at_terminal;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if (flags !== 5'b10010) $display("FAIL term_press: got %b, want 10010", flags);
    else pass_cnt++;
    for (int i = 1; i < 8; i++) begin
      tick();
      total_cnt++;
      if (flags !== ((i == 5) ? 5'b00111 : ((i > 5) ? 5'b00001 : 5'b00000)))
        $display("FAIL term_k+%0d: got %b", i, flags);
      else pass_cnt++;
    end
    debounced = 1'b0;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b01000, 8'd1})
      $display("FAIL term_release: got %b/%0d, want 01000/1", flags, rpt_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b00000, 8'd1})
      $display("FAIL term_count_held: got %b/%0d, want 00000/1", flags, rpt_count);
    else pass_cnt++;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b10010, 8'd0})
      $display("FAIL term_repress: got %b/%0d, want 10010/0", flags, rpt_count);
    else pass_cnt++;
    debounced = 1'b0;
    tick();
    total_cnt++;
    if (flags !== 5'b01000) $display("FAIL term_rerelease: got %b, want 01000", flags);
    else pass_cnt++;
    $display("test_fall_at_terminal done");
  endtask

  task automatic test_saturation;
    logic       exp_rpt;
    logic [7:0] exp_cnt;
    int         pulses;
    exp_cnt = 8'd0;
    pulses  = 0;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if (flags !== 5'b10010) $display("FAIL sat_press: got %b, want 10010", flags);
    else pass_cnt++;
    for (int i = 1; i < 800; i++) begin
      tick();
      exp_rpt = (i >= 5) && ((i - 5) % 3 == 0);
      if (exp_rpt && exp_cnt != 8'd255) exp_cnt++;
      if (rpt_pulse) pulses++;
      total_cnt++;
      if ({flags, rpt_count} !== {2'b00, exp_rpt, exp_rpt, (i >= 5), exp_cnt})
        $display("FAIL sat_k+%0d: got %b/%0d, want %b/%0d", i, flags, rpt_count,
                 {2'b00, exp_rpt, exp_rpt, (i >= 5)}, exp_cnt);
      else pass_cnt++;
    end
    total_cnt++;
    if (pulses != 265) $display("FAIL sat_pulse_total: got %0d, want 265", pulses);
    else pass_cnt++;
    debounced = 1'b0;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b01000, 8'd255})
      $display("FAIL sat_release: got %b/%0d, want 01000/255", flags, rpt_count);
    else pass_cnt++;
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid_repeat;
    debounced = 1'b1;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b10010, 8'd0})
      $display("FAIL midrst_press: got %b/%0d, want 10010/0", flags, rpt_count);
    else pass_cnt++;
    repeat (5) tick();
    total_cnt++;
    if ({flags, rpt_count} !== {5'b00111, 8'd1})
      $display("FAIL midrst_first_rpt: got %b/%0d, want 00111/1", flags, rpt_count);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({flags, rpt_count} !== 13'd0)
      $display("FAIL midrst_cleared: got %b, want 0", {flags, rpt_count});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (flags !== 5'b10010) $display("FAIL midrst_repress: got %b, want 10010", flags);
    else pass_cnt++;
    debounced = 1'b0;
    tick();
    total_cnt++;
    if (flags !== 5'b01000) $display("FAIL midrst_release: got %b, want 01000", flags);
    else pass_cnt++;
    $display("test_reset_mid_repeat done");
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_seq [5];
    logic       din_seq [5];
    exp_seq = '{5'b10010, 5'b01000, 5'b10010, 5'b01000, 5'b00000};
    din_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      debounced = din_seq[i];
      tick();
      total_cnt++;
      if (flags !== exp_seq[i])
        $display("FAIL b2b_%0d: got %b, want %b", i, flags, exp_seq[i]);
      else pass_cnt++;
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b1;
    debounced = 1'b0;
    test_reset();
    test_hold20();
    test_short_press();
    test_fall_at_terminal();
    test_saturation();
    test_reset_mid_repeat();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
